// File: rtl/modulo_verificador_ataque_pkg.sv
// Shared definitions for the attack checker: board geometry, RGB result codes
// and FSM state encoding.
package modulo_verificador_ataque_pkg;

   localparam int LINHAS   = 7;
   localparam int COLUNAS  = 5;
   localparam int NCELULAS = LINHAS * COLUNAS;
   localparam int IDXW     = 6;

   localparam logic [IDXW-1:0] ULTIMA_CELULA = IDXW'(NCELULAS - 1);

   typedef logic [1:0] rgb_t;

   localparam rgb_t RGB_NADA     = 2'b00;
   localparam rgb_t RGB_AGUA     = 2'b01;
   localparam rgb_t RGB_ACERTO   = 2'b10;
   localparam rgb_t RGB_REPETIDO = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_MARK,
      ST_WAIT,
      ST_SCAN,
      ST_DONE
   } estado_t;

   // Row-major cell index; callers must range-check the coordinate first.
   function automatic logic [IDXW-1:0] indice_celula(input logic [2:0] linha,
                                                     input logic [2:0] coluna);
      return IDXW'(linha) * IDXW'(COLUNAS) + IDXW'(coluna);
   endfunction

endpackage

// File: rtl/modulo_verificador_ataque_varredura.sv
// Board scanner: after a start pulse, walks every cell once and counts ship
// cells that have not been attacked yet.
module modulo_varredura_navios
   import modulo_verificador_ataque_pkg::*;
(
   input  logic                clk,
   input  logic                clr,
   input  logic                start_i,
   input  logic                abort_i,
   input  logic [NCELULAS-1:0] m_po_i,
   input  logic [NCELULAS-1:0] m_at_i,
   output logic                done_o,
   output logic [IDXW-1:0]     count_o
);

   logic [IDXW-1:0] cnt_q;
   logic [IDXW-1:0] acc_q;
   logic            busy_q;
   logic            celula_viva;

   // Cell order does not matter for the count, so the counter indexes bits directly.
   assign celula_viva = m_po_i[cnt_q] & m_at_i[cnt_q];
   assign done_o      = busy_q && (cnt_q == ULTIMA_CELULA);
   assign count_o     = acc_q + IDXW'(celula_viva);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cnt_q  <= '0;
         acc_q  <= '0;
         busy_q <= 1'b0;
      end else if (abort_i || start_i) begin
         cnt_q  <= '0;
         acc_q  <= '0;
         busy_q <= start_i && !abort_i;
      end else if (busy_q) begin
         acc_q <= count_o;
         if (done_o) begin
            busy_q <= 1'b0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/modulo_verificador_ataque.sv
// Resolves one attack shot: classifies it, marks the attack matrix, rescans
// the fleet and reports the RGB result and game-over.
module modulo_verificador_ataque
   import modulo_verificador_ataque_pkg::*;
(
   input  logic                clk,
   input  logic                clr,
   input  logic                novo_jogo,
   input  logic                atk_valid,
   input  logic [2:0]          atk_linha,
   input  logic [2:0]          atk_coluna,
   input  logic [NCELULAS-1:0] m_po,
   input  logic [NCELULAS-1:0] m_at,
   output logic                atk_ready,
   output logic                wr_en,
   output logic [IDXW-1:0]     wr_idx,
   output logic [1:0]          rgb,
   output logic                result_valid,
   output logic [IDXW-1:0]     acertos,
   output logic [IDXW-1:0]     restantes,
   output logic                game_over
);

   estado_t         state_q;
   logic [2:0]      linha_q;
   logic [2:0]      coluna_q;
   rgb_t            classe_q;
   rgb_t            rgb_q;
   logic            wr_en_q;
   logic [IDXW-1:0] wr_idx_q;
   logic            result_valid_q;
   logic [IDXW-1:0] acertos_q;
   logic [IDXW-1:0] restantes_q;
   logic            game_over_q;

   logic            coord_ok;
   logic [IDXW-1:0] idx;
   logic [IDXW-1:0] pos;
   logic            scan_done;
   logic [IDXW-1:0] scan_count;

   assign coord_ok = (32'(linha_q) < LINHAS) && (32'(coluna_q) < COLUNAS);
   assign idx      = indice_celula(linha_q, coluna_q);
   assign pos      = ULTIMA_CELULA - idx;

   modulo_varredura_navios u_varredura (
      .clk     (clk),
      .clr     (clr),
      .start_i (state_q == ST_WAIT),
      .abort_i (novo_jogo),
      .m_po_i  (m_po),
      .m_at_i  (m_at),
      .done_o  (scan_done),
      .count_o (scan_count)
   );

   // Outputs are registered on the transition into the state that owns them,
   // so wr_en is high exactly during MARK and result_valid during DONE.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q        <= ST_IDLE;
         linha_q        <= '0;
         coluna_q       <= '0;
         classe_q       <= RGB_NADA;
         rgb_q          <= RGB_NADA;
         wr_en_q        <= 1'b0;
         wr_idx_q       <= '0;
         result_valid_q <= 1'b0;
         acertos_q      <= '0;
         restantes_q    <= '0;
         game_over_q    <= 1'b0;
      end else if (novo_jogo) begin
         state_q        <= ST_IDLE;
         classe_q       <= RGB_NADA;
         rgb_q          <= RGB_NADA;
         wr_en_q        <= 1'b0;
         wr_idx_q       <= '0;
         result_valid_q <= 1'b0;
         acertos_q      <= '0;
         restantes_q    <= '0;
         game_over_q    <= 1'b0;
      end else begin
         wr_en_q        <= 1'b0;
         result_valid_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (atk_valid && !game_over_q) begin
                  linha_q  <= atk_linha;
                  coluna_q <= atk_coluna;
                  state_q  <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (!coord_ok || !m_at[pos]) begin
                  classe_q       <= RGB_REPETIDO;
                  rgb_q          <= RGB_REPETIDO;
                  result_valid_q <= 1'b1;
                  state_q        <= ST_DONE;
               end else begin
                  classe_q <= m_po[pos] ? RGB_ACERTO : RGB_AGUA;
                  if (m_po[pos]) begin
                     acertos_q <= acertos_q + 1'b1;
                  end
                  wr_en_q  <= 1'b1;
                  wr_idx_q <= idx;
                  state_q  <= ST_MARK;
               end
            end
            ST_MARK: state_q <= ST_WAIT;
            ST_WAIT: state_q <= ST_SCAN;
            ST_SCAN: begin
               if (scan_done) begin
                  restantes_q    <= scan_count;
                  rgb_q          <= classe_q;
                  result_valid_q <= 1'b1;
                  if (classe_q == RGB_ACERTO && scan_count == '0) begin
                     game_over_q <= 1'b1;
                  end
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign atk_ready    = (state_q == ST_IDLE) && !game_over_q;
   assign wr_en        = wr_en_q;
   assign wr_idx       = wr_idx_q;
   assign rgb          = rgb_q;
   assign result_valid = result_valid_q;
   assign acertos      = acertos_q;
   assign restantes    = restantes_q;
   assign game_over    = game_over_q;

endmodule

// File: doc/modulo_verificador_ataque.md
Name: modulo_verificador_ataque

Overview:
Resolves one attack shot against the stored fleet. It consumes a confirmed attack coordinate and reads the position matrix and the attack matrix. It classifies the shot as miss, hit, repeat or invalid, and issues a single-cell write back to the attack matrix. It then rescans the board to count the ship cells still standing, drives the 2-bit RGB result, and raises game-over. It sits between the attack coordinate counter and the attack register matrix, on the reader side of the position matrix.

Parameters:
LINHAS, 7, board rows (linha 0..LINHAS-1)
COLUNAS, 5, board columns (coluna 0..COLUNAS-1)
NCELULAS, LINHAS*COLUNAS (35), matrix width; cell index idx = linha*COLUNAS + coluna, stored at bit NCELULAS-1-idx

Ports:
clk  in  1  system clock
clr  in  1  reset; asynchronous, active-low (0 = reset)
novo_jogo  in  1  synchronous 1-cycle pulse; aborts the current operation and clears game state
atk_valid  in  1  1-cycle pulse; attack coordinate is valid
atk_linha  in  3  attack row
atk_coluna  in  3  attack column
m_po  in  35  position matrix; bit=1 means ship cell
m_at  in  35  attack matrix; bit=0 means already attacked
atk_ready  out  1  high only in IDLE with game_over=0
wr_en  out  1  1-cycle pulse; external matrix must clear bit wr_idx on the next clk edge
wr_idx  out  6  cell index being marked (0..34)
rgb  out  2  00 none, 01 miss, 10 hit, 11 repeat/invalid; held until next result
result_valid  out  1  1-cycle pulse when rgb is updated
acertos  out  6  total hits this game
restantes  out  6  unattacked ship cells after the last scan
game_over  out  1  sticky; set when restantes=0 after a hit

Behaviour:
- Reset (clr=0, async): state=IDLE; rgb=00; wr_en=0; wr_idx=0; result_valid=0; acertos=0; restantes=0; game_over=0. Reset mid-operation abandons the shot and issues no write.
- novo_jogo=1: same values as reset, applied on the clock edge. It has priority over atk_valid and over any state.
- States: IDLE, CHECK, MARK, WAIT, SCAN, DONE.
- IDLE: when atk_valid=1 and atk_ready=1, latch linha/coluna and go to CHECK. atk_valid is ignored in every other state and when game_over=1.
- CHECK (1 cycle): compute idx.
  - linha>=LINHAS or coluna>=COLUNAS: class=invalid, go to DONE.
  - Else if m_at bit = 0: class=repeat, go to DONE.
  - Else if m_po bit = 1: class=hit, acertos+1, go to MARK.
  - Else: class=miss, go to MARK.
- MARK (1 cycle): wr_en=1, wr_idx=idx, go to WAIT.
- WAIT (1 cycle): lets the external matrix update, then go to SCAN.
- SCAN (NCELULAS cycles): scan counter runs 0..34. The accumulator counts cells with m_po=1 and m_at=1. On the last cell, restantes is loaded and the state goes to DONE.
- DONE (1 cycle): rgb=class code; result_valid=1. If class=hit and restantes=0, game_over=1. Then go to IDLE.
- Latency, accepted atk_valid at edge 0:
  - miss/hit: result_valid asserted in cycle 39 (CHECK 1, MARK 1, WAIT 1, SCAN 35, DONE 1).
  - repeat/invalid: result_valid asserted in cycle 2.
- Repeat and invalid shots never assert wr_en and never change acertos or restantes.
- Counters are 6 bits and cannot exceed 35, so there is no wrap.
- A miss with restantes already 0 does not set game_over.

Decomposition:
- Shared package: LINHAS, COLUNAS, NCELULAS; RGB codes RGB_NADA=00, RGB_AGUA=01, RGB_ACERTO=10, RGB_REPETIDO=11; state encoding.
- One sub-module, modulo_varredura_navios: start pulse; 35-cycle scan counter and remaining-ship accumulator; outputs done and count.
- The top level keeps the FSM, classification and write port.

Test Plan:
1. Bench matrix models the write-back. m_po has a ship only at (0,0) (bit 34), m_at all 1s; attack (0,0) -> CHECK=hit; wr_en pulse with wr_idx=0 at cycle 2; result_valid at cycle 39 with rgb=10, acertos=1, restantes=0, game_over=1.
2. m_po ships at (1,2),(1,3); attack (3,4) -> wr_idx=19; rgb=01; restantes=2; acertos=0; game_over=0.
3. Repeat: attack (1,2) twice -> second shot gives result_valid at cycle 2, rgb=11, no wr_en, acertos unchanged.
4. Invalid: attack (7,0), then (2,5) -> both give rgb=11 at cycle 2, no write.
5. atk_valid pulses during SCAN and while game_over=1 -> ignored; atk_ready=0 in both cases.
6. Mid-scan events:
   - Pull clr low mid-SCAN -> all outputs go to reset values immediately; no result_valid.
   - Pulse novo_jogo mid-SCAN -> IDLE next edge; acertos=0; game_over=0.
